stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Multi-cycle sequencer for the control-flow instructions the single-cycle decoder cannot complete in one pass: CALL, RET, RETI, and hardware interrupt entry (INT). It owns the stack pointer and drives the shared 16-bit data-memory port. It stalls the pipeline while active, then issues a single PC-load/flush pulse.

Parameters:
ADDR_W, 20, data-memory word-address width; also the SP width.
SP_INIT, 20'hFFFFF, SP value after reset.
PC_W, 32, program-counter width; always two memory words.

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; op and operands are valid in the same cycle.
op  in  2  request type: 0 CALL, 1 RET, 2 RETI, 3 INT.
return_pc  in  PC_W  PC to save (CALL, INT).
target_pc  in  PC_W  CALL destination.
flags_in  in  3  CCR to save (INT).
mem_ready  in  1  memory accepts the current access this cycle; read data is valid in the same cycle.
mem_rdata  in  16  read data.
mem_rd  out  1  read request.
mem_wr  out  1  write request.
mem_addr  out  ADDR_W  access address.
mem_wdata  out  16  write data.
sp  out  ADDR_W  current stack pointer.
busy  out  1  state != IDLE.
stall  out  1  busy | start; combinational, so fetch freezes in the start cycle.
pc_load  out  1  one-cycle pulse: load pc_out into the PC.
pc_out  out  PC_W  new PC, valid while pc_load = 1.
flush  out  1  equals pc_load.
flags_load  out  1  one-cycle pulse (RETI only): restore CCR.
flags_out  out  3  restored flags.
done  out  1  one-cycle pulse, coincident with pc_load.
err  out  1  one-cycle pulse: start received while busy.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, sp = SP_INIT.
  - Every other output = 0.
  - An operation in progress is abandoned; no pc_load is issued.
- Stack is full-descending; SP points to the next free word.
  - Push: write at SP, then SP = SP - 1.
  - Pop: SP = SP + 1, then read at the new SP.
  - SP arithmetic is modulo 2^ADDR_W; wrap is silent.
- A PC is pushed high word first, then low word; it is popped low word first, then high word.
- Start handling in IDLE: start latches op, return_pc, target_pc and flags_in into internal registers. The next state is chosen by op:
  - CALL -> PUSH_HI.
  - RET or RETI -> POP_LO.
  - INT -> PUSH_FLG.
- States:
  - PUSH_FLG: write {13'b0, flags}. Goes to PUSH_HI.
  - PUSH_HI: write return_pc[31:16]. Goes to PUSH_LO.
  - PUSH_LO: write return_pc[15:0]. Goes to FINISH for CALL, VEC_LO for INT.
  - POP_LO: read at SP + 1. Goes to POP_HI.
  - POP_HI: read at SP + 1. Goes to FINISH for RET, POP_FLG for RETI.
  - POP_FLG: read at SP + 1; capture bits [2:0]. Goes to FINISH.
  - VEC_LO: read address 0. Goes to VEC_HI.
  - VEC_HI: read address 1. Goes to FINISH.
  - FINISH: pc_load = done = flush = 1 for one cycle. RETI also pulses flags_load. pc_out is:
    - CALL: target_pc.
    - RET and RETI: {popped hi, popped lo}.
    - INT: {vec hi, vec lo}.
    Then returns to IDLE.
- Memory handshake:
  - In each memory state, mem_rd or mem_wr, mem_addr and mem_wdata stay stable until mem_ready = 1.
  - The state advances, SP updates and read data is captured only in a cycle with mem_ready = 1.
  - mem_rd and mem_wr are never both 1. Both are 0 in IDLE and FINISH.
- Latency from the start cycle to the pc_load cycle, with mem_ready held at 1:
  - CALL: 3 cycles.
  - RET: 3 cycles.
  - RETI: 4 cycles.
  - INT: 6 cycles.
  - Each cycle with mem_ready = 0 in a memory state adds 1.
- start while busy (including the FINISH cycle): the request is ignored, err pulses for 1 cycle, and state is unchanged.
- start in IDLE with rst_n just released: accepted normally.

Test Plan:
- Reset, then CALL with return_pc = 0x00000123, target_pc = 0x00000400, mem_ready = 1 -> writes (0xFFFFF, 0x0000) then (0xFFFFE, 0x0123); pc_load at start + 3 with pc_out = 0x00000400; sp = 0xFFFFD.
- RET following the previous test, with a memory model -> reads 0xFFFFE then 0xFFFFF; pc_out = 0x00000123 at start + 3; sp = 0xFFFFF.
- INT with flags_in = 3'b101, return_pc = 0x00010020, mem[0] = 0x0200, mem[1] = 0x0000 -> writes 0x0005 @ FFFFF, 0x0001 @ FFFFE, 0x0020 @ FFFFD; pc_out = 0x00000200 at start + 6. Then RETI -> flags_load with flags_out = 101, pc_out = 0x00010020, sp = 0xFFFFF.
- CALL with mem_ready = 0 for 2 cycles during PUSH_LO -> mem_addr/mem_wdata held at 0xFFFFE/0x0123; sp stays 0xFFFFE; pc_load at start + 5.
- start during a busy CALL, and RET popping from sp = 0xFFFFF -> err pulses once and the first op completes unchanged; the RET reads 0x00000 then 0x00001 (wrap) and ends with sp = 0x00001.
- rst_n low in the VEC_LO state of an INT -> all outputs 0 immediately, sp = 0xFFFFF, no pc_load; a new CALL after release completes normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Multi-cycle sequencer for CALL, RET, RETI and hardware interrupt entry.
// It owns the stack pointer and drives the shared 16-bit data-memory port.
// The pipeline is stalled while it is active. At the end it issues a single
// pc_load/flush/done pulse.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start, op           one-cycle request (0 CALL, 1 RET, 2 RETI, 3 INT)
//   return_pc           PC to save (CALL, INT)
//   target_pc           CALL destination
//   flags_in            CCR to save (INT)
//   mem_ready           memory accepts the current access; read data valid
//   mem_rdata           read data
//   mem_rd, mem_wr      access requests (never both high)
//   mem_addr, mem_wdata access address and write data
//   sp                  current stack pointer (full-descending)
//   busy, stall         sequencer active; busy | start
//   pc_load, pc_out     one-cycle PC load pulse and the new PC
//   flush, done         both equal pc_load
//   flags_load, flags_out  CCR restore pulse (RETI) and the restored flags
//   err                 start received while busy
//
// Memory handshake: while in a memory state, mem_rd/mem_wr, mem_addr and
// mem_wdata are held constant. The access completes in the first cycle with
// mem_ready = 1. Only in that cycle does the state advance, SP move, and
// read data get captured.
// ---------------------------------------------------------------------------
module stack_sequencer #(
  parameter int                ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] SP_INIT = 20'hFFFFF,
  parameter int                PC_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [PC_W-1:0]   return_pc,
  input  logic [PC_W-1:0]   target_pc,
  input  logic [2:0]        flags_in,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] sp,
  output logic              busy,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              flush,
  output logic              flags_load,
  output logic [2:0]        flags_out,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] OP_CALL = 2'd0;
  localparam logic [1:0] OP_RETI = 2'd2;
  localparam logic [1:0] OP_INT  = 2'd3;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_FLG, S_PUSH_HI, S_PUSH_LO, S_POP_LO,
    S_POP_HI, S_POP_FLG, S_VEC_LO, S_VEC_HI, S_FINISH
  } state_t;

  state_t            state, next_state;
  logic [1:0]        op_q;
  logic [PC_W-1:0]   ret_q;
  logic [PC_W-1:0]   tgt_q;
  logic [2:0]        flg_q;
  logic [15:0]       lo_q;
  logic [15:0]       hi_q;
  logic [2:0]        flags_q;

  logic is_push, is_pop;

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    pc_load    = 1'b0;
    flags_load = 1'b0;
    pc_out     = '0;
    is_push    = 1'b0;
    is_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_CALL: next_state = S_PUSH_HI;
            OP_INT:  next_state = S_PUSH_FLG;
            default: next_state = S_POP_LO;
          endcase
        end
      end
      S_PUSH_FLG: begin
        mem_wr    = 1'b1;
        mem_addr  = sp;
        mem_wdata = {13'b0, flg_q};
        is_push   = 1'b1;
        if (mem_ready) next_state = S_PUSH_HI;
      end
      S_PUSH_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = sp;
        mem_wdata = ret_q[31:16];
        is_push   = 1'b1;
        if (mem_ready) next_state = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = sp;
        mem_wdata = ret_q[15:0];
        is_push   = 1'b1;
        if (mem_ready) next_state = (op_q == OP_INT) ? S_VEC_LO : S_FINISH;
      end
      S_POP_LO: begin
        mem_rd   = 1'b1;
        mem_addr = sp + ONE;
        is_pop   = 1'b1;
        if (mem_ready) next_state = S_POP_HI;
      end
      S_POP_HI: begin
        mem_rd   = 1'b1;
        mem_addr = sp + ONE;
        is_pop   = 1'b1;
        if (mem_ready) next_state = (op_q == OP_RETI) ? S_POP_FLG : S_FINISH;
      end
      S_POP_FLG: begin
        mem_rd   = 1'b1;
        mem_addr = sp + ONE;
        is_pop   = 1'b1;
        if (mem_ready) next_state = S_FINISH;
      end
      S_VEC_LO: begin
        mem_rd   = 1'b1;
        mem_addr = '0;
        if (mem_ready) next_state = S_VEC_HI;
      end
      S_VEC_HI: begin
        mem_rd   = 1'b1;
        mem_addr = ONE;
        if (mem_ready) next_state = S_FINISH;
      end
      S_FINISH: begin
        pc_load    = 1'b1;
        flags_load = (op_q == OP_RETI);
        // Popped words and vector words share the lo/hi capture registers.
        pc_out     = (op_q == OP_CALL) ? tgt_q : {hi_q, lo_q};
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sp      <= SP_INIT;
      op_q    <= '0;
      ret_q   <= '0;
      tgt_q   <= '0;
      flg_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && start) begin
        op_q  <= op;
        ret_q <= return_pc;
        tgt_q <= target_pc;
        flg_q <= flags_in;
      end
      if (mem_ready) begin
        // SP wraps silently modulo 2^ADDR_W.
        if (is_push) sp <= sp - ONE;
        if (is_pop)  sp <= sp + ONE;
        case (state)
          S_POP_LO, S_VEC_LO: lo_q    <= mem_rdata;
          S_POP_HI, S_VEC_HI: hi_q    <= mem_rdata;
          S_POP_FLG:          flags_q <= mem_rdata[2:0];
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign stall     = busy | start;
  assign err       = start & busy;
  assign done      = pc_load;
  assign flush     = pc_load;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_sequencer
//
// Directed bench for stack_sequencer. The drivers issue requests and push
// the memory accesses and PC loads they should produce into queues. A
// negedge monitor pops and compares those entries whenever the DUT completes
// an access or pulses pc_load. A small memory model serves the reads.
// ---------------------------------------------------------------------------
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] return_pc = '0;
  logic [31:0] target_pc = '0;
  logic [2:0]  flags_in = '0;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_rdata;
  logic        mem_rd, mem_wr;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [19:0] sp;
  logic        busy, stall, pc_load, flush, flags_load, done, err;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  stack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .return_pc(return_pc), .target_pc(target_pc), .flags_in(flags_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sp(sp), .busy(busy), .stall(stall),
    .pc_load(pc_load), .pc_out(pc_out), .flush(flush),
    .flags_load(flags_load), .flags_out(flags_out), .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  // Only the low 4 address bits are decoded; the addresses used here
  // (0, 1, FFFFD..FFFFF) do not alias.
  logic [15:0] mem [0:15];
  assign mem_rdata = mem_rd ? mem[mem_addr[3:0]] : 16'h0;

  // ---------------- scoreboard ----------------
  logic [36:0] acc_q[$];   // {wr, addr, wdata}
  logic [87:0] pc_q[$];    // {cycle, pc, flags_load, flags, sp}
  int checks = 0;
  int passes = 0;
  int err_exp = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [36:0] acc(input logic wr, input logic [19:0] a,
                                      input logic [15:0] d);
    return {wr, a, d};
  endfunction

  function automatic logic [87:0] pcv(input int c, input logic [31:0] pc,
                                      input logic fl, input logic [2:0] f,
                                      input logic [19:0] s);
    return {c, pc, fl, f, s};
  endfunction

  always @(negedge clk) begin
    logic [36:0] ea;
    logic [87:0] ep;
    if (rst_n) begin
      if (err) err_seen++;
      if (mem_ready && (mem_rd || mem_wr)) begin
        check("rd_wr_exclusive", {mem_rd, mem_wr} == 2'b11, 1'b0);
        if (acc_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_access: got %0h expected none",
                   {mem_wr, mem_addr, mem_wdata});
        end else begin
          ea = acc_q.pop_front();
          check("mem_access", {mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0}, ea);
        end
        if (mem_wr) mem[mem_addr[3:0]] = mem_wdata;
      end
      if (pc_load || done || flush) begin
        check("done_flush", {pc_load, done, flush}, 3'b111);
        if (pc_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pc_load: got pc %0h expected none", pc_out);
        end else begin
          ep = pc_q.pop_front();
          check("pc_event", {cyc, pc_out, flags_load,
                             flags_load ? flags_out : 3'b0, sp}, ep);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] rpc,
                       input logic [31:0] tpc, input logic [2:0] f,
                       output int sc);
    @(posedge clk); #1;
    start = 1'b1; op = o; return_pc = rpc; target_pc = tpc; flags_in = f;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_idle: busy stayed 1, expected 0 within 40 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {mem_rd, mem_wr, mem_addr, mem_wdata, busy, pc_load, pc_out,
                 flush, flags_load, flags_out, done, err}, '0);
    check({name, "_sp"}, sp, 20'hFFFFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sc;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0] = 16'h0200;
    mem[1] = 16'h0000;

    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    // CALL right after reset release
    issue(2'd0, 32'h0000_0123, 32'h0000_0400, 3'd0, sc);
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'hFFFFE, 16'h0123));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0400, 1'b0, 3'd0, 20'hFFFFD));
    wait_idle();

    // RET
    issue(2'd1, '0, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b0, 20'hFFFFE, 16'h0));
    acc_q.push_back(acc(1'b0, 20'hFFFFF, 16'h0));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0123, 1'b0, 3'd0, 20'hFFFFF));
    wait_idle();

    // INT
    issue(2'd3, 32'h0001_0020, '0, 3'b101, sc);
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0005));
    acc_q.push_back(acc(1'b1, 20'hFFFFE, 16'h0001));
    acc_q.push_back(acc(1'b1, 20'hFFFFD, 16'h0020));
    acc_q.push_back(acc(1'b0, 20'h00000, 16'h0));
    acc_q.push_back(acc(1'b0, 20'h00001, 16'h0));
    pc_q.push_back(pcv(sc + 6, 32'h0000_0200, 1'b0, 3'd0, 20'hFFFFC));
    wait_idle();

    // RETI
    issue(2'd2, '0, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b0, 20'hFFFFD, 16'h0));
    acc_q.push_back(acc(1'b0, 20'hFFFFE, 16'h0));
    acc_q.push_back(acc(1'b0, 20'hFFFFF, 16'h0));
    pc_q.push_back(pcv(sc + 4, 32'h0001_0020, 1'b1, 3'b101, 20'hFFFFF));
    wait_idle();

    // CALL with two wait cycles in PUSH_LO
    issue(2'd0, 32'h0000_0123, 32'h0000_0999, 3'd0, sc);
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'hFFFFE, 16'h0123));
    pc_q.push_back(pcv(sc + 5, 32'h0000_0999, 1'b0, 3'd0, 20'hFFFFD));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      check("stall_hold", {mem_wr, mem_rd, mem_addr, mem_wdata, sp},
            {1'b1, 1'b0, 20'hFFFFE, 16'h0123, 20'hFFFFE});
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    wait_idle();

    // RET to rebalance the stack
    issue(2'd1, '0, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b0, 20'hFFFFE, 16'h0));
    acc_q.push_back(acc(1'b0, 20'hFFFFF, 16'h0));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0123, 1'b0, 3'd0, 20'hFFFFF));
    wait_idle();

    // CALL with a second start while busy
    issue(2'd0, 32'h0000_0456, 32'h0000_0800, 3'd0, sc);
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'hFFFFE, 16'h0456));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0800, 1'b0, 3'd0, 20'hFFFFD));
    start = 1'b1; op = 2'd1;
    err_exp++;
    @(negedge clk);
    check("err_while_busy", {err, stall}, 2'b11);
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // RET back to FFFFF, then RET that wraps the stack pointer
    issue(2'd1, '0, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b0, 20'hFFFFE, 16'h0));
    acc_q.push_back(acc(1'b0, 20'hFFFFF, 16'h0));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0456, 1'b0, 3'd0, 20'hFFFFF));
    wait_idle();
    issue(2'd1, '0, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b0, 20'h00000, 16'h0));
    acc_q.push_back(acc(1'b0, 20'h00001, 16'h0));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0200, 1'b0, 3'd0, 20'h00001));
    wait_idle();

    // INT aborted by reset in VEC_LO
    issue(2'd3, 32'h0000_0200, '0, 3'd0, sc);
    acc_q.push_back(acc(1'b1, 20'h00001, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'h00000, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0200));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // CALL after release
    issue(2'd0, 32'h0000_0789, 32'h0000_0ABC, 3'd0, sc);
    acc_q.push_back(acc(1'b1, 20'hFFFFF, 16'h0000));
    acc_q.push_back(acc(1'b1, 20'hFFFFE, 16'h0789));
    pc_q.push_back(pcv(sc + 3, 32'h0000_0ABC, 1'b0, 3'd0, 20'hFFFFD));
    wait_idle();

    repeat (3) @(negedge clk);
    check("acc_queue_empty", acc_q.size(), 0);
    check("pc_queue_empty", pc_q.size(), 0);
    check("err_count", err_seen, err_exp);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
